vector_mem_sequencer: RTL and testbench
=======================================

// Module: vector_mem_sequencer
// PURPOSE
//  Memory-side responder for the load/store controls the decoder produces (memREN, memWEN, isVector).
//  Accepts one scalar or vector load/store per request and serialises the THREADS lane accesses onto
//  the single-port data memory interface (dmemREN/dmemWEN/dwait).
//  Collects per-lane load data and reports completion to the datapath with a one-cycle done pulse.
// PARAMETERS
//  THREADS  4   number of vector lanes; lane counter width = $clog2(THREADS), minimum 1
// PORTS
//  CLK         in   1           clock, rising edge
//  nRST        in   1           asynchronous active-low reset
//  req_ren     in   1           load request (memREN from control)
//  req_wen     in   1           store request (memWEN from control)
//  req_vec     in   1           1 = vector access (all enabled lanes), 0 = scalar (lane 0 only)
//  lane_en     in   THREADS     per-lane enable; vector only; disabled lanes are skipped
//  req_addr    in   THREADS*32  per-lane byte address (word_t each)
//  req_wdata   in   THREADS*32  per-lane store data
//  busy        out  1           request accepted and not yet completed
//  resp_done   out  1           one-cycle pulse: request complete, resp_rdata valid
//  resp_rdata  out  THREADS*32  per-lane load data, held until the next load updates the lane
//  dmemREN     out  1           data memory read strobe
//  dmemWEN     out  1           data memory write strobe
//  dmemaddr    out  32          word address, bits[1:0] forced to 2'b00
//  dmemstore   out  32          store data of the current lane
//  dmemload    in   32          load data; valid when dwait==0
//  dwait       in   1           1 = memory stalled; the access completes in the first cycle with dwait==0
// BEHAVIOUR
//  Reset (async, nRST=0): state IDLE; busy, resp_done, dmemREN, dmemWEN = 0; dmemaddr, dmemstore = 0;
//   resp_rdata all 0; lane counter 0. Strobes drop in the same instant, even mid-access.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: exactly one of req_ren/req_wen high -> latch ren/wen/vec, lane_en, addr, wdata;
//    effective mask = vec ? lane_en : 'b1 (lane 0 only); counter = lowest set lane; go ACCESS.
//    Both high, or both low: no action, remain IDLE.
//    Effective mask all zero (vector, lane_en==0): go DONE directly; no memory access.
//   ACCESS: busy=1; drive dmemREN or dmemWEN, dmemaddr={addr[lane][31:2],2'b00}, dmemstore=wdata[lane].
//    dwait==1: hold all outputs. dwait==0: on a load, capture dmemload into resp_rdata[lane].
//    Then go to the next higher enabled lane, or go DONE if none remain.
//    Strobes stay high across back-to-back lanes. Only the address and data change.
//   DONE: strobes 0, busy=0, resp_done=1 for exactly one cycle; next state IDLE.
//    No new request is accepted in DONE.
//  Inputs are latched once per request; requester changes during ACCESS have no effect.
//  Latency: request sampled at edge 0; with dwait=0 throughout, lane k's access occupies cycle k+1.
//   resp_done is high in cycle N+1, where N = number of enabled lanes (scalar N=1).
//  Stores never modify resp_rdata; disabled lanes keep their previous resp_rdata value.
//  Lane counter never wraps: the last enabled lane always exits to DONE.
// TESTING
//  Scalar load addr 0x104, dwait=0, dmemload=0xDEAD -> dmemaddr=0x104 for 1 cycle; resp_rdata[0]=0xDEAD, resp_done 2 cycles after accept.
//  Vector store, 4 lanes, addr 0x0/0x4/0x8/0xC, wdata 1..4 -> 4 consecutive dmemWEN cycles in lane order; resp_done in cycle 5.
//  Vector load, lane_en=4'b1010, dwait=1 for 3 cycles per access -> only lanes 1,3 accessed, each held 4 cycles; lanes 0,2 resp_rdata unchanged.
//  Vector load with lane_en=0 -> no dmem strobe; resp_done pulses in cycle 1.
//  req_ren=req_wen=1 -> stays IDLE, busy=0, no strobes; then nRST low during lane 2 of a vector load -> strobes and resp_rdata 0 immediately.
//  Unaligned addr 0x107 -> dmemaddr=0x104; req_addr changed mid-ACCESS -> dmemaddr unaffected.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Memory-side responder for decoded load/store controls. One scalar or vector
// request is latched in IDLE, its enabled lanes are walked in ascending order
// over the single-port data memory interface, and completion is reported with
// a one-cycle resp_done pulse. Per-lane load data is kept in resp_rdata.
//
// Memory handshake: while dmemREN or dmemWEN is high the access is offered;
// it completes in the first cycle in which dwait is low. Until then address,
// store data and strobes are held unchanged. Strobes remain high across
// back-to-back lanes; only dmemaddr/dmemstore move to the next lane.
//
// dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 DONE).
module vector_mem_sequencer #(
    parameter int THREADS = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    req_ren,
    input  logic                    req_wen,
    input  logic                    req_vec,
    input  logic [THREADS-1:0]      lane_en,
    input  logic [THREADS*32-1:0]   req_addr,
    input  logic [THREADS*32-1:0]   req_wdata,
    output logic                    busy,
    output logic                    resp_done,
    output logic [THREADS*32-1:0]   resp_rdata,
    output logic                    dmemREN,
    output logic                    dmemWEN,
    output logic [31:0]             dmemaddr,
    output logic [31:0]             dmemstore,
    input  logic [31:0]             dmemload,
    input  logic                    dwait,
    output logic [1:0]              dbg_state
);

    // Lane counter width; at least one bit even for a single lane.
    localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Returns {found, index} of the lowest set bit of mask at or above 'from'.
    // Scanning downwards lets the last hit be the lowest qualifying lane.
    function automatic logic [LW:0] find_lane(input logic [THREADS-1:0] mask,
                                              input int from);
        logic [LW:0] res;
        res = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res = {1'b1, LW'(i)};
            end
        end
        return res;
    endfunction

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_is_load;
    logic [THREADS-1:0]      r_mask;
    logic [THREADS*32-1:0]   r_addr;
    logic [THREADS*32-1:0]   r_wdata;
    logic [LW-1:0]           r_lane;
    logic [THREADS*32-1:0]   r_rdata;

    logic                    w_req_accept;
    logic [THREADS-1:0]      w_req_mask;
    logic [LW:0]             w_first;
    logic [LW:0]             w_next;
    logic                    w_lane_complete;
    logic [31:0]             w_lane_addr;
    logic [31:0]             w_lane_wdata;

    // Exactly one of load/store requested while idle; both or neither is ignored.
    assign w_req_accept = (r_state == ST_IDLE) && (req_ren ^ req_wen);

    // Scalar accesses always use lane 0 regardless of lane_en.
    assign w_req_mask = req_vec ? lane_en : THREADS'(1);

    // First lane of a new request, and the next lane after the current one.
    assign w_first = find_lane(w_req_mask, 0);
    assign w_next  = find_lane(r_mask, int'(r_lane) + 1);

    // The current lane finishes in an ACCESS cycle with the memory not stalled.
    assign w_lane_complete = (r_state == ST_ACCESS) && !dwait;

    assign resp_rdata = r_rdata;
    assign dbg_state  = r_state;

    // Select the latched address and store data of the current lane.
    always_comb begin
        w_lane_addr  = '0;
        w_lane_wdata = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (LW'(i) == r_lane) begin
                w_lane_addr  = r_addr[i*32 +: 32];
                w_lane_wdata = r_wdata[i*32 +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore outputs; strobes come straight from the state so
    // an asynchronous reset drops them immediately.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        resp_done    = 1'b0;
        dmemREN      = 1'b0;
        dmemWEN      = 1'b0;
        dmemaddr     = '0;
        dmemstore    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_accept) begin
                    // An all-zero vector mask has nothing to access.
                    w_next_state = (w_req_mask == '0) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy      = 1'b1;
                dmemREN   = r_is_load;
                dmemWEN   = !r_is_load;
                dmemaddr  = {w_lane_addr[31:2], 2'b00};
                dmemstore = w_lane_wdata;
                if (!dwait && !w_next[LW]) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_done    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the whole request once, so requester changes during ACCESS are ignored.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_is_load <= 1'b0;
            r_mask    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_req_accept) begin
            r_is_load <= req_ren;
            r_mask    <= w_req_mask;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
        end
    end

    // Lane counter: start at the lowest enabled lane, step to the next enabled
    // lane on completion; the last lane leaves the counter in place (no wrap).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_lane <= '0;
        end else if (w_req_accept) begin
            r_lane <= w_first[LW-1:0];
        end else if (w_lane_complete && w_next[LW]) begin
            r_lane <= w_next[LW-1:0];
        end
    end

    // Capture load data into the current lane; stores and skipped lanes keep old data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rdata <= '0;
        end else if (w_lane_complete && r_is_load) begin
            for (int i = 0; i < THREADS; i++) begin
                if (LW'(i) == r_lane) begin
                    r_rdata[i*32 +: 32] <= dmemload;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: directed requests, a small memory
// responder with programmable stall length, and two monitors that pop the
// expected memory accesses and responses from queues.
module tb_vector_mem_sequencer;
  localparam int T = 4;
  localparam int W = T * 32;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic           req_ren, req_wen, req_vec;
  logic [T-1:0]   lane_en;
  logic [W-1:0]   req_addr, req_wdata;
  logic           busy, resp_done;
  logic [W-1:0]   resp_rdata;
  logic           dmemREN, dmemWEN;
  logic [31:0]    dmemaddr, dmemstore, dmemload;
  logic           dwait;
  logic [1:0]     dbg_state;

  vector_mem_sequencer #(.THREADS(T)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_vec(req_vec),
    .lane_en(lane_en), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_done(resp_done), .resp_rdata(resp_rdata),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dwait(dwait),
    .dbg_state(dbg_state)
  );

  // ---------------- memory responder ----------------
  logic [31:0] mem [0:63];
  int wait_n = 0;
  int wcnt;
  assign dmemload = mem[dmemaddr[7:2]];
  assign dwait = (dmemREN || dmemWEN) && (wcnt < wait_n);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wcnt <= 0;
    else if (dmemREN || dmemWEN) wcnt <= dwait ? wcnt + 1 : 0;
    else wcnt <= 0;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [72:0]  acc_q[$];   // {wen, addr[31:0], store[31:0], hold[7:0]}

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                          input int hold);
    acc_q.push_back({wen, addr, data, 8'(hold)});
  endtask

  // Access monitor: one expected entry per completed memory access.
  int hold_cnt = 0;
  logic [72:0] acc_e;
  always @(negedge CLK) begin
    if (!nRST) begin
      hold_cnt = 0;
    end else if (dmemREN || dmemWEN) begin
      hold_cnt++;
      if (!dwait) begin
        if (acc_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_access: got addr %h expected none", dmemaddr);
        end else begin
          acc_e = acc_q.pop_front();
          check("acc_wen", W'(dmemWEN), W'(acc_e[72]));
          check("acc_ren", W'(dmemREN), W'(!acc_e[72]));
          check("acc_addr", W'(dmemaddr), W'(acc_e[71:40]));
          if (acc_e[72]) check("acc_store", W'(dmemstore), W'(acc_e[39:8]));
          check("acc_hold", W'(hold_cnt), W'(acc_e[7:0]));
        end
        hold_cnt = 0;
      end
    end
  end

  // Response monitor: rdata and completion cycle on every resp_done.
  logic prev_done = 1'b0;
  logic [W-1:0] resp_e;
  int cyc_e;
  always @(negedge CLK) begin
    if (prev_done) check("done_pulse_width", W'(resp_done), '0);
    if (resp_done) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got resp_done=1 expected 0");
      end else begin
        resp_e = exp_q.pop_front();
        cyc_e  = exp_cyc_q.pop_front();
        check("resp_rdata", resp_rdata, resp_e);
        check("done_cycle", W'(cyc), W'(cyc_e));
        check("busy_at_done", W'(busy), '0);
      end
    end
    prev_done = resp_done;
  end

  // ---------------- driver tasks ----------------
  // Present a request at a falling edge; it is sampled at the next rising edge.
  // lat is the hand-computed number of cycles from acceptance to resp_done.
  task automatic do_req(input logic ren, input logic wen, input logic vec,
                        input logic [T-1:0] en, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input bit expect_done,
                        input logic [W-1:0] exp_rdata, input int lat);
    int c0;
    @(negedge CLK);
    req_ren = ren; req_wen = wen; req_vec = vec;
    lane_en = en; req_addr = addr; req_wdata = wdata;
    @(posedge CLK);
    #1;
    c0 = cyc;
    if (expect_done) begin
      exp_q.push_back(exp_rdata);
      exp_cyc_q.push_back(c0 + lat);
    end
    req_ren = 1'b0; req_wen = 1'b0;
  endtask

  task automatic drain();
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && acc_q.size() == 0 && !busy && !resp_done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge CLK);
    end
    check("drain_timeout", W'(timed_out), '0);
    if (timed_out) begin
      exp_q.delete(); exp_cyc_q.delete(); acc_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[6'h41] = 32'h0000_DEAD;
    mem[9]     = 32'hCAFE_0001;
    mem[11]    = 32'hCAFE_0003;
    mem[12]    = 32'h0C0C_0C0C;
    mem[14]    = 32'h0E0E_0E0E;

    nRST = 1'b0;
    req_ren = 1'b0; req_wen = 1'b0; req_vec = 1'b0;
    lane_en = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(resp_done), '0);
    check("rst_strobes", W'({dmemREN, dmemWEN}), '0);
    check("rst_addr", W'(dmemaddr), '0);
    check("rst_store", W'(dmemstore), '0);
    check("rst_rdata", resp_rdata, '0);
    check("rst_state", W'(dbg_state), '0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Scalar load 0x104; lane_en ignored for scalar.
    wait_n = 0;
    push_acc(1'b0, 32'h104, 32'h0, 1);
    do_req(1'b1, 1'b0, 1'b0, 4'b1111, {32'h0, 32'h0, 32'h0, 32'h104}, '0,
           1'b1, {32'h0, 32'h0, 32'h0, 32'h0000_DEAD}, 1);
    drain();

    // Vector store, 4 lanes, back-to-back.
    push_acc(1'b1, 32'h0, 32'd1, 1);
    push_acc(1'b1, 32'h4, 32'd2, 1);
    push_acc(1'b1, 32'h8, 32'd3, 1);
    push_acc(1'b1, 32'hC, 32'd4, 1);
    do_req(1'b0, 1'b1, 1'b1, 4'b1111, {32'hC, 32'h8, 32'h4, 32'h0},
           {32'd4, 32'd3, 32'd2, 32'd1},
           1'b1, {32'h0, 32'h0, 32'h0, 32'h0000_DEAD}, 4);
    drain();

    // Vector load lanes 1,3 with 3 stall cycles each.
    wait_n = 3;
    push_acc(1'b0, 32'h24, 32'h0, 4);
    push_acc(1'b0, 32'h2C, 32'h0, 4);
    do_req(1'b1, 1'b0, 1'b1, 4'b1010, {32'h2C, 32'h28, 32'h24, 32'h20}, '0,
           1'b1, {32'hCAFE_0003, 32'h0, 32'hCAFE_0001, 32'h0000_DEAD}, 8);
    drain();

    // Vector load with no lanes enabled: straight to DONE.
    do_req(1'b1, 1'b0, 1'b1, 4'b0000, {32'h2C, 32'h28, 32'h24, 32'h20}, '0,
           1'b1, {32'hCAFE_0003, 32'h0, 32'hCAFE_0001, 32'h0000_DEAD}, 0);
    drain();

    // Both request lines high: ignored.
    @(negedge CLK);
    req_ren = 1'b1; req_wen = 1'b1; req_vec = 1'b1; lane_en = 4'b1111;
    repeat (3) begin
      @(negedge CLK);
      check("both_busy", W'(busy), '0);
      check("both_state", W'(dbg_state), '0);
    end
    req_ren = 1'b0; req_wen = 1'b0;
    drain();

    // Unaligned scalar load; requester address changes mid-access.
    wait_n = 2;
    mem[6'h41] = 32'h5A5A_1234;
    push_acc(1'b0, 32'h104, 32'h0, 3);
    do_req(1'b1, 1'b0, 1'b0, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h107}, '0,
           1'b1, {32'hCAFE_0003, 32'h0, 32'hCAFE_0001, 32'h5A5A_1234}, 3);
    req_addr = {32'h0, 32'h0, 32'h0, 32'h200};
    #1;
    check("addr_hold", W'(dmemaddr), W'(32'h104));
    drain();

    // Vector load lanes 0,2 with one stall cycle each.
    wait_n = 1;
    push_acc(1'b0, 32'h30, 32'h0, 2);
    push_acc(1'b0, 32'h38, 32'h0, 2);
    do_req(1'b1, 1'b0, 1'b1, 4'b0101, {32'h3C, 32'h38, 32'h34, 32'h30}, '0,
           1'b1, {32'hCAFE_0003, 32'h0E0E_0E0E, 32'hCAFE_0001, 32'h0C0C_0C0C}, 4);
    drain();

    // Reset asserted while lane 2 of a vector load is on the bus.
    wait_n = 0;
    push_acc(1'b0, 32'h40, 32'h0, 1);
    push_acc(1'b0, 32'h44, 32'h0, 1);
    do_req(1'b1, 1'b0, 1'b1, 4'b1111, {32'h4C, 32'h48, 32'h44, 32'h40}, '0,
           1'b0, '0, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("lane2_addr", W'(dmemaddr), W'(32'h48));
    nRST = 1'b0;
    #1;
    check("midrst_strobes", W'({dmemREN, dmemWEN}), '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_addr", W'(dmemaddr), '0);
    check("midrst_rdata", resp_rdata, '0);
    check("midrst_state", W'(dbg_state), '0);
    @(negedge CLK);
    nRST = 1'b1;
    drain();

    // Recovery after reset: scalar load 0x30.
    push_acc(1'b0, 32'h30, 32'h0, 1);
    do_req(1'b1, 1'b0, 1'b0, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h30}, '0,
           1'b1, {32'h0, 32'h0, 32'h0, 32'h0C0C_0C0C}, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
